// File: rtl/radix6_input_sorter_if.sv
// Sample-in / triplet-out bus of the radix-6 input sorter.
// in_valid qualifies in_sof/in_re/in_img; out_valid qualifies a/b/c and out_grp; there is no ready (no backpressure).
interface radix6_input_sorter_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_img;
  logic              out_valid;
  logic              out_grp;
  logic [DATA_W-1:0] a_re;
  logic [DATA_W-1:0] a_img;
  logic [DATA_W-1:0] b_re;
  logic [DATA_W-1:0] b_img;
  logic [DATA_W-1:0] c_re;
  logic [DATA_W-1:0] c_img;
  logic              frame_done;
  logic              sof_err;

  modport master (
    output in_valid, in_sof, in_re, in_img,
    input  out_valid, out_grp, a_re, a_img, b_re, b_img, c_re, c_img,
    input  frame_done, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_img,
    output out_valid, out_grp, a_re, a_img, b_re, b_img, c_re, c_img,
    output frame_done, sof_err
  );
endinterface

// File: rtl/radix6_input_sorter.sv
// Collects 6-sample frames into a ping-pong buffer and emits each frame as an
// even triplet (x0,x2,x4) then an odd triplet (x1,x3,x5) for the radix-3 stage.
module radix6_input_sorter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  radix6_input_sorter_if.slave  io,
  output logic [1:0]            rd_state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GRP0 = 2'd1,
    GRP1 = 2'd2
  } rd_state_e;

  rd_state_e         state_q, state_d;
  logic [2:0]        wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        full_set, full_clr;
  logic              out_valid_q, out_valid_d;
  logic              out_grp_q, out_grp_d;
  logic              frame_done_q, frame_done_d;
  logic              sof_err_q, sof_err_d;
  logic [DATA_W-1:0] a_re_q, a_re_d, a_img_q, a_img_d;
  logic [DATA_W-1:0] b_re_q, b_re_d, b_img_q, b_img_d;
  logic [DATA_W-1:0] c_re_q, c_re_d, c_img_q, c_img_d;
  logic              wr_en;
  logic [2:0]        wr_slot;
  logic [DATA_W-1:0] bank_re_q  [2][6];
  logic [DATA_W-1:0] bank_img_q [2][6];

  // Write side: a sof restarts the current bank at slot 0, discarding any partial frame.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    sof_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_slot   = wr_cnt_q;
    if (io.in_valid) begin
      wr_en = 1'b1;
      if (io.in_sof) begin
        wr_slot   = 3'd0;
        wr_cnt_d  = 3'd1;
        sof_err_d = (wr_cnt_q != 3'd0);
      end else if (wr_cnt_q == 3'd5) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_cnt_d            = 3'd0;
      end else begin
        wr_cnt_d = wr_cnt_q + 3'd1;
      end
    end
  end

  // Read side: two-cycle emission per frame, release of the bank on the odd triplet.
  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    full_clr     = 2'b00;
    out_valid_d  = 1'b0;
    out_grp_d    = out_grp_q;
    frame_done_d = 1'b0;
    a_re_d       = a_re_q;
    a_img_d      = a_img_q;
    b_re_d       = b_re_q;
    b_img_d      = b_img_q;
    c_re_d       = c_re_q;
    c_img_d      = c_img_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = GRP0;
      end
      GRP0: begin
        out_valid_d = 1'b1;
        out_grp_d   = 1'b0;
        a_re_d      = bank_re_q[rd_bank_q][3'd0];
        a_img_d     = bank_img_q[rd_bank_q][3'd0];
        b_re_d      = bank_re_q[rd_bank_q][3'd2];
        b_img_d     = bank_img_q[rd_bank_q][3'd2];
        c_re_d      = bank_re_q[rd_bank_q][3'd4];
        c_img_d     = bank_img_q[rd_bank_q][3'd4];
        state_d     = GRP1;
      end
      GRP1: begin
        out_valid_d         = 1'b1;
        out_grp_d           = 1'b1;
        frame_done_d        = 1'b1;
        a_re_d              = bank_re_q[rd_bank_q][3'd1];
        a_img_d             = bank_img_q[rd_bank_q][3'd1];
        b_re_d              = bank_re_q[rd_bank_q][3'd3];
        b_img_d             = bank_img_q[rd_bank_q][3'd3];
        c_re_d              = bank_re_q[rd_bank_q][3'd5];
        c_img_d             = bank_img_q[rd_bank_q][3'd5];
        full_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        state_d             = full_q[~rd_bank_q] ? GRP0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Set and clear always target different banks, so the order is immaterial.
    full_d = (full_q & ~full_clr) | full_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_cnt_q     <= 3'd0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= 2'b00;
      out_valid_q  <= 1'b0;
      out_grp_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      a_re_q       <= '0;
      a_img_q      <= '0;
      b_re_q       <= '0;
      b_img_q      <= '0;
      c_re_q       <= '0;
      c_img_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      out_valid_q  <= out_valid_d;
      out_grp_q    <= out_grp_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      a_re_q       <= a_re_d;
      a_img_q      <= a_img_d;
      b_re_q       <= b_re_d;
      b_img_q      <= b_img_d;
      c_re_q       <= c_re_d;
      c_img_q      <= c_img_d;
    end
  end

  // Sample storage carries no reset; its contents are only read behind a full flag.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_re_q[wr_bank_q][wr_slot]  <= io.in_re;
      bank_img_q[wr_bank_q][wr_slot] <= io.in_img;
    end
  end

  // The read side always frees a bank before the writer wraps back onto it.
  assert property (@(posedge clk) disable iff (rst) !(io.in_valid && full_q[wr_bank_q]))
    else $error("write into a bank that is still full");

  assign io.out_valid  = out_valid_q;
  assign io.out_grp    = out_grp_q;
  assign io.frame_done = frame_done_q;
  assign io.sof_err    = sof_err_q;
  assign io.a_re       = a_re_q;
  assign io.a_img      = a_img_q;
  assign io.b_re       = b_re_q;
  assign io.b_img      = b_img_q;
  assign io.c_re       = c_re_q;
  assign io.c_img      = c_img_q;
  assign rd_state_dbg  = state_q;

endmodule

// File: tb/tb_radix6_input_sorter.sv
// Directed and randomized checks of radix6_input_sorter against a frame-level
// model: each completed 6-sample frame predicts two triplets at fixed edges.
module tb_radix6_input_sorter;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rd_state_dbg;

  always #5 clk = ~clk;

  radix6_input_sorter_if #(.DATA_W(W)) io ();

  radix6_input_sorter #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .io           (io),
    .rd_state_dbg (rd_state_dbg)
  );

  typedef struct packed {
    int unsigned edge_n;
    logic        grp;
    logic [W-1:0] a_re, a_img, b_re, b_img, c_re, c_img;
  } trip_t;

  trip_t        exp_q[$];
  logic [W-1:0] frm_re[$];
  logic [W-1:0] frm_img[$];
  trip_t        last = '0;
  int unsigned  edge_n = 0;
  int unsigned  sof_err_edge = 32'hFFFF_FFFF;
  int           errors = 0;
  int           checks = 0;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the edge just taken.
  task automatic check_outputs();
    trip_t t;
    logic  ev;
    ev = (exp_q.size() != 0) && (exp_q[0].edge_n == edge_n);
    if (ev) begin
      t    = exp_q.pop_front();
      last = t;
    end
    chk("out_valid", {31'd0, io.out_valid}, {31'd0, ev});
    chk("out_grp", {31'd0, io.out_grp}, {31'd0, last.grp});
    chk("frame_done", {31'd0, io.frame_done}, {31'd0, ev && last.grp});
    chk("sof_err", {31'd0, io.sof_err}, {31'd0, sof_err_edge == edge_n});
    chk("a_re", io.a_re, last.a_re);
    chk("a_img", io.a_img, last.a_img);
    chk("b_re", io.b_re, last.b_re);
    chk("b_img", io.b_img, last.b_img);
    chk("c_re", io.c_re, last.c_re);
    chk("c_img", io.c_img, last.c_img);
  endtask

  task automatic step(input logic v, input logic sof, input logic [W-1:0] re, input logic [W-1:0] im);
    int unsigned e;
    trip_t       t;
    @(negedge clk);
    io.in_valid = v;
    io.in_sof   = sof;
    io.in_re    = re;
    io.in_img   = im;
    e = edge_n + 1;
    if (v) begin
      if (sof) begin
        if (frm_re.size() != 0) sof_err_edge = e;
        frm_re.delete();
        frm_img.delete();
      end
      frm_re.push_back(re);
      frm_img.push_back(im);
      if (frm_re.size() == 6) begin
        t.edge_n = e + 2;
        t.grp    = 1'b0;
        t.a_re = frm_re[0]; t.a_img = frm_img[0];
        t.b_re = frm_re[2]; t.b_img = frm_img[2];
        t.c_re = frm_re[4]; t.c_img = frm_img[4];
        exp_q.push_back(t);
        t.edge_n = e + 3;
        t.grp    = 1'b1;
        t.a_re = frm_re[1]; t.a_img = frm_img[1];
        t.b_re = frm_re[3]; t.b_img = frm_img[3];
        t.c_re = frm_re[5]; t.c_img = frm_img[5];
        exp_q.push_back(t);
        frm_re.delete();
        frm_img.delete();
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain_check();
    idle(5);
    chk("drain", exp_q.size(), 0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    frm_re.delete();
    frm_img.delete();
    last         = '0;
    sof_err_edge = 32'hFFFF_FFFF;
    check_outputs();
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in_sof   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.in_sof   = 1'b0;
    io.in_re    = '0;
    io.in_img   = '0;

    do_reset();

    // Single frame re=1..6, img=-1..-6.
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, W'(i), W'(-i));
    drain_check();

    // Four frames back to back.
    for (int i = 1; i <= 24; i++) step(1'b1, 1'b0, W'(i), W'(-i));
    drain_check();

    // Two random frames with ~50% gaps.
    for (int i = 0; i < 12; i++) begin
      while ($urandom_range(0, 1) == 1) idle(1);
      step(1'b1, 1'b0, W'($urandom), W'($urandom));
    end
    drain_check();

    // sof after three samples truncates the frame.
    step(1'b1, 1'b1, W'(10), W'(-10));
    step(1'b1, 1'b0, W'(11), W'(-11));
    step(1'b1, 1'b0, W'(12), W'(-12));
    step(1'b1, 1'b1, W'(20), W'(-20));
    for (int i = 21; i <= 25; i++) step(1'b1, 1'b0, W'(i), W'(-i));
    drain_check();

    // sof on the cycle that would complete a frame wins.
    for (int i = 70; i <= 74; i++) step(1'b1, 1'b0, W'(i), W'(-i));
    step(1'b1, 1'b1, W'(80), W'(-80));
    for (int i = 81; i <= 85; i++) step(1'b1, 1'b0, W'(i), W'(-i));
    drain_check();

    // Reset while the even triplet is on the outputs.
    for (int i = 30; i <= 35; i++) step(1'b1, 1'b0, W'(i), W'(-i));
    idle(2);
    do_reset();
    idle(4);
    for (int i = 40; i <= 45; i++) step(1'b1, 1'b0, W'(i), W'(-i));
    drain_check();

    // sof without in_valid mid-frame is ignored.
    step(1'b1, 1'b0, W'(50), W'(-50));
    step(1'b1, 1'b0, W'(51), W'(-51));
    step(1'b1, 1'b0, W'(52), W'(-52));
    step(1'b0, 1'b1, W'(99), W'(-99));
    step(1'b1, 1'b0, W'(53), W'(-53));
    step(1'b1, 1'b0, W'(54), W'(-54));
    step(1'b1, 1'b0, W'(55), W'(-55));
    drain_check();

    // Random mix of gaps, occasional sof and random data.
    for (int i = 0; i < 120; i++) begin
      logic v, s;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 19) == 0);
      step(v, s, W'($urandom), W'($urandom));
    end
    drain_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/radix6_input_sorter.md
Name: radix6_input_sorter

Overview:
- Serial-to-parallel input stage directly upstream of the radix-3 butterfly pipeline in the radix-6 FFT.
- Accepts one complex sample per cycle and collects 6-sample frames in a ping-pong buffer.
- Emits each frame as two complex triplets, the radix-2 x radix-3 decimation: group 0 = x0,x2,x4; group 1 = x1,x3,x5.
- Outputs map one-to-one onto the a/b/c re/img inputs of the radix-3 pipeline.

Parameters:
- DATA_W, 32, width of each real/imag component (opaque data; no arithmetic performed).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample on in_re/in_img is valid this cycle.
- in_sof  input  1  start of frame; qualified by in_valid.
- in_re  input  DATA_W  sample real part.
- in_img  input  DATA_W  sample imaginary part.
- out_valid  output  1  triplet on a/b/c outputs is valid.
- out_grp  output  1  0 = even triplet (x0,x2,x4), 1 = odd triplet (x1,x3,x5).
- a_re, a_img  output  DATA_W each  triplet element 0 (x0 or x1).
- b_re, b_img  output  DATA_W each  triplet element 1 (x2 or x3).
- c_re, c_img  output  DATA_W each  triplet element 2 (x4 or x5).
- frame_done  output  1  one-cycle pulse coincident with group-1 output.
- sof_err  output  1  one-cycle pulse when in_sof truncates a partial frame.

Behaviour:
- Reset (async, rst=1): all outputs 0. wr_cnt=0, wr_bank=0, both bank-full flags 0, read FSM in IDLE. Buffer contents are don't-care.
- Write side:
  - On in_valid, store the sample in bank[wr_bank] slot wr_cnt.
  - If in_sof=1 with in_valid, the sample goes to slot 0 and wr_cnt becomes 1.
  - If that sof arrives with wr_cnt != 0, the partial frame is discarded and sof_err pulses next cycle.
  - If wr_cnt=5 and no sof: set full[wr_bank], toggle wr_bank, set wr_cnt to 0.
  - in_sof without in_valid is ignored. Gaps (in_valid=0) hold wr_cnt.
  - in_sof is not required. Frames also delimit by count alone.
- Read FSM states: IDLE, GRP0, GRP1. rd_bank starts at 0.
  - IDLE -> GRP0 when full[rd_bank]=1.
  - GRP0 (1 cycle): register bank slots 0,2,4 onto a,b,c. out_valid=1, out_grp=0. -> GRP1.
  - GRP1 (1 cycle): register slots 1,3,5. out_valid=1, out_grp=1, frame_done=1. Clear full[rd_bank], toggle rd_bank.
    - Go to GRP0 if full[new rd_bank] is already set, else IDLE.
  - The full flag is observed one cycle after it is set.
- Latency: if slot 5 is written at edge k, group 0 is valid after edge k+2 and group 1 after edge k+3.
- Outputs are registered. When out_valid=0, the data outputs hold their last value and out_grp holds. frame_done and sof_err are pulses.
- Throughput: the read side needs 2 cycles per frame and the write side at least 6, so a bank is always released before it is rewritten. No backpressure exists.
  - Writing into a bank whose full flag is still set is a design-invariant violation. Cover it with an assertion, not logic.
- Simultaneous events:
  - A write of slot 5 into one bank in the same cycle the other bank is read and released is legal; both happen.
  - in_sof on the cycle that would complete a frame: sof wins. The partial frame is dropped and sof_err pulses.
- Reset mid-frame or mid-read: immediate return to reset state. Any partially emitted frame is lost; no further out_valid until a new full frame is written.

Test Plan:
- Reset then 6 continuous samples re=1..6, img=-1..-6 -> out_valid on cycles 8 and 9 after first sample; grp0 a/b/c re=1,3,5, img=-1,-3,-5; grp1 re=2,4,6, img=-2,-4,-6; frame_done with grp1.
- 24 back-to-back samples (4 frames, in_valid always 1) -> 8 triplets, exactly 2 out_valid per 6 cycles, banks alternate, no data mixing (e.g. frame 3 grp0 re=13,15,17).
- Random in_valid gaps (50%) across 2 frames -> same triplets as the gap-free case; wr_cnt holds during gaps.
- in_sof at sample 3 of a frame (samples 10,11,12 then sof sample 20..25) -> sof_err pulse once; only frame 20..25 is emitted (grp0 re=20,22,24).
- Assert rst during GRP0 output -> all outputs 0 immediately; no GRP1 emitted; the next full frame is emitted normally.
- in_sof with in_valid=0 mid-frame -> ignored, no sof_err, frame completes normally.
